systolic_feeder: RTL and testbench

Transmit-side companion to the 4x4 output-stationary systolic array. The block buffers operand matrices A (NxN) and B (NxN) written by a host over a valid/ready load port. On start, it clears the array and drives the diagonally skewed west (A rows) and north (B columns) streams. It then pulses done when every array accumulator holds its final C = A*B value.

---
 rtl/systolic_feeder.sv | 113 +++++++++++
 tb/tb_systolic_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand buffer and skewed west/north stream driver for an NxN output-stationary systolic array.
// FEEDER_AUTOCLR_EN adds a one-cycle CLEAR state that pulses arr_rst before each feed.
module systolic_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 ld_sel,
  input  logic [$clog2(N)-1:0] ld_row,
  input  logic [$clog2(N)-1:0] ld_col,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 arr_rst,
  output logic [N*OUT_W-1:0]   west_o,
  output logic [N*OUT_W-1:0]   north_o
);

  localparam int IW     = $clog2(N);
  localparam int T_LAST = 3*N - 3;
  localparam int TW     = $clog2(3*N - 2);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FEED, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [TW-1:0]       t, t_nxt;
  logic [DATA_W-1:0]   mem_a [N][N];
  logic [DATA_W-1:0]   mem_b [N][N];
  logic [N*OUT_W-1:0]  west_nxt, north_nxt;
  logic                ld_fire;

  assign ld_ready = (state == S_IDLE);
  assign ld_fire  = ld_valid && ld_ready;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
`ifdef FEEDER_AUTOCLR_EN
  assign arr_rst  = (state == S_CLEAR);
`else
  assign arr_rst  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      S_IDLE: begin
        // A load in the same cycle as start wins; start is dropped.
        if (start && !ld_valid) begin
`ifdef FEEDER_AUTOCLR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_FEED;
`endif
          t_nxt = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        t_nxt     = '0;
      end
      S_FEED: begin
        if (t == TW'(T_LAST)) state_nxt = S_DONE;
        else                  t_nxt     = t + TW'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lanes are computed for the upcoming phase so the registered outputs line up with it.
  always_comb begin
    west_nxt  = '0;
    north_nxt = '0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if (int'(t_nxt) >= i && int'(t_nxt) <= i + N - 1) begin
          west_nxt[i*OUT_W +: OUT_W]  = OUT_W'(mem_a[i][IW'(int'(t_nxt) - i)]);
          north_nxt[i*OUT_W +: OUT_W] = OUT_W'(mem_b[IW'(int'(t_nxt) - i)][i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      t       <= '0;
      west_o  <= '0;
      north_o <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem_a[r][c] <= '0;
          mem_b[r][c] <= '0;
        end
      end
    end else begin
      state   <= state_nxt;
      t       <= t_nxt;
      west_o  <= west_nxt;
      north_o <= north_nxt;
      if (ld_fire) begin
        if (ld_sel) mem_b[ld_row][ld_col] <= ld_data;
        else        mem_a[ld_row][ld_col] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed table, corner sequences and random runs against a matrix-level model.
// Build with or without FEEDER_AUTOCLR_EN; expected latency follows the macro.
module tb_systolic_feeder;
  localparam int N = 4, DATA_W = 16, OUT_W = 32;
`ifdef FEEDER_AUTOCLR_EN
  localparam int F0 = 2;
  localparam bit AUTOCLR = 1'b1;
`else
  localparam int F0 = 1;
  localparam bit AUTOCLR = 1'b0;
`endif
  localparam int LAT = F0 + 3*N - 2;
  localparam int WIN = LAT + 3;

  logic clk = 1'b0;
  logic rst, ld_valid, ld_ready, ld_sel, start, busy, done, arr_rst;
  logic [1:0] ld_row, ld_col;
  logic [DATA_W-1:0] ld_data;
  logic [N*OUT_W-1:0] west_o, north_o;

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start), .busy(busy),
    .done(done), .arr_rst(arr_rst), .west_o(west_o), .north_o(north_o));

  int vectors = 0, miscompares = 0;
  longint ma [N][N], mb [N][N], acc [N][N], exp_acc [N][N];
  longint rw [WIN][N], rn [WIN][N];
  bit rdone [WIN], rar [WIN], rbusy [WIN];

  typedef struct { int t; bit north; int lane; longint exp; } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane(input logic [N*OUT_W-1:0] bus, input int i);
    return longint'(bus[i*OUT_W +: OUT_W]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int r, input int c, input longint d);
    ld_valid = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_col = 2'(c); ld_data = DATA_W'(d);
    tick;
    ld_valid = 1'b0;
    if (sel) mb[r][c] = d; else ma[r][c] = d;
  endtask

  task automatic host_clear;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin acc[i][j] = 0; exp_acc[i][j] = 0; end
  endtask

  task automatic model_zero;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_west"}, longint'(west_o != '0), 0);
    check({tag, "_north"}, longint'(north_o != '0), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_arr_rst"}, longint'(arr_rst), 0);
    check({tag, "_ld_ready"}, longint'(ld_ready), 1);
  endtask

  // Cycle 0 is the cycle start is held high; the run is recorded then judged against the model.
  task automatic run(input bit inject);
    int ndone, first;
    for (int c = 0; c < WIN; c++) begin
      if (c > 0) tick;
      start = (c == 0);
      if (inject) begin
        ld_valid = (c >= F0 + 1 && c <= F0 + 4);
        ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 16'hBEEF;
        if (ld_valid) check("ld_ready_in_feed", longint'(ld_ready), 0);
      end
      for (int i = 0; i < N; i++) begin rw[c][i] = lane(west_o, i); rn[c][i] = lane(north_o, i); end
      rdone[c] = done; rar[c] = arr_rst; rbusy[c] = busy;
    end
    ld_valid = 1'b0;
    ndone = 0; first = -1;
    for (int c = 0; c < WIN; c++) if (rdone[c]) begin ndone++; if (first < 0) first = c; end
    check("done_cycle", first, LAT);
    check("done_count", ndone, 1);
    for (int c = 0; c < WIN; c++) begin
      int t = c - F0;
      bit feed = (t >= 0 && t <= 3*N - 3);
      check("busy", longint'(rbusy[c]), longint'(c >= 1 && c <= LAT));
      check("arr_rst", longint'(rar[c]), longint'(AUTOCLR && c == 1));
      for (int i = 0; i < N; i++) begin
        longint ew = 0, en = 0;
        int k = t - i;
        if (feed && k >= 0 && k < N) begin ew = ma[i][k]; en = mb[k][i]; end
        check($sformatf("west_c%0d_l%0d", c, i), rw[c][i], ew);
        check($sformatf("north_c%0d_l%0d", c, i), rn[c][i], en);
      end
    end
    // Array model: PE(i,j) sees the west lane delayed by j and the north lane delayed by i.
    for (int c = 0; c < WIN; c++) begin
      if (rar[c]) for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (c >= i && c >= j) acc[i][j] += rw[c-j][i] * rn[c-i][j];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (AUTOCLR) exp_acc[i][j] = 0;
        for (int k = 0; k < N; k++) exp_acc[i][j] += ma[i][k] * mb[k][j];
        check($sformatf("result_%0d_%0d", i, j), acc[i][j], exp_acc[i][j]);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    tbl[0]  = '{0, 1'b0, 0, 1};  tbl[1]  = '{0, 1'b0, 1, 0};
    tbl[2]  = '{0, 1'b0, 2, 0};  tbl[3]  = '{0, 1'b0, 3, 0};
    tbl[4]  = '{0, 1'b1, 0, 1};  tbl[5]  = '{0, 1'b1, 1, 0};
    tbl[6]  = '{3, 1'b1, 3, 4};  tbl[7]  = '{3, 1'b1, 0, 13};
    tbl[8]  = '{2, 1'b0, 1, 1};  tbl[9]  = '{3, 1'b0, 1, 0};
    tbl[10] = '{6, 1'b0, 3, 1};  tbl[11] = '{6, 1'b1, 3, 16};

    rst = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0;
    ld_data = '0; start = 1'b0;
    tick; tick;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    rst = 1'b0;
    repeat (5) tick;
    check_idle("idle");
    model_zero; host_clear;
    run(0);

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, longint'(r == c));
        load(1'b1, r, c, 4*r + c + 1);
      end
    run(0);
    for (int e = 0; e < 12; e++)
      check($sformatf("tbl%0d", e),
            tbl[e].north ? rn[F0 + tbl[e].t][tbl[e].lane] : rw[F0 + tbl[e].t][tbl[e].lane],
            tbl[e].exp);
    run(0);

    host_clear;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin load(1'b0, r, c, 2); load(1'b1, r, c, 2); end
    run(0);
    check_idle("after_done");

    ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 16'd7; start = 1'b1;
    tick;
    ld_valid = 1'b0; start = 1'b0; ma[0][0] = 7;
    check("start_with_load_busy", longint'(busy), 0);
    check("start_with_load_ready", longint'(ld_ready), 1);
    run(0);
    check("west0_t0_after_load", rw[F0][0], 7);

    run(1);
    run(0);

    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (F0 + 3) tick;
    check("midrun_busy_t4", longint'(busy), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_idle("midrun_rst");
    model_zero;
    nd = 0;
    for (int c = 0; c < 20; c++) begin tick; if (done) nd++; end
    check("midrun_no_done", nd, 0);
    host_clear;
    run(0);

    for (int n = 0; n < 3; n++) begin
      host_clear;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          load(1'b0, r, c, longint'($urandom_range(0, 65535)));
          load(1'b1, r, c, longint'($urandom_range(0, 65535)));
        end
      run(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
